// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with generic width and depth. The read port is either registered
// or first-word-fall-through. It reports occupancy, threshold flags and sticky errors.
module param_sync_fifo #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic                     wpush,
    input  logic [DATA_W-1:0]        wdata,
    output logic                     wfull,
    input  logic                     rpop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rempty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]  wptr_q, wptr_d;
    logic [LVL_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              push_acc, pop_acc;

    // All status flags decode the level register directly, so they share its timing.
    assign wfull        = (level_q == LVL_W'(DEPTH));
    assign rempty       = (level_q == '0);
    assign almost_full  = (level_q >= LVL_W'(AFULL_TH));
    assign almost_empty = (level_q <= LVL_W'(AEMPTY_TH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        pop_acc  = rpop && !rempty;
        // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
        push_acc = wpush && (!wfull || pop_acc);

        wptr_d = wptr_q;
        if (push_acc) begin
            wptr_d = wptr_q + LVL_W'(1);
        end
        rptr_d = rptr_q;
        if (pop_acc) begin
            rptr_d = rptr_q + LVL_W'(1);
        end

        level_d = level_q;
        case ({push_acc, pop_acc})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A new error event takes priority over a clear in the same cycle.
        overflow_d  = (overflow_q && !err_clr) || (wpush && !push_acc);
        underflow_d = (underflow_q && !err_clr) || (rpop && !pop_acc);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The storage array has no reset so that it can map onto block RAM.
    always_ff @(posedge wclk) begin
        if (!wrst && push_acc) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= wdata;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem_q[rptr_q[ADDR_W-1:0]];
        end else begin : g_reg
            logic [DATA_W-1:0] rdata_q;
            always_ff @(posedge wclk) begin
                if (wrst) begin
                    rdata_q <= '0;
                end else if (pop_acc) begin
                    rdata_q <= mem_q[rptr_q[ADDR_W-1:0]];
                end
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Testbench for param_sync_fifo. A registered-read instance and an FWFT instance share
// the same stimulus and are checked against a queue-based reference model.
module tb_param_sync_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = 4;

    logic          wclk = 1'b0;
    logic          wrst = 1'b0, wpush = 1'b0, rpop = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic [DW-1:0] rdata_o [2];
    logic [LW-1:0] level_o [2];
    logic          wfull_o [2], rempty_o [2], af_o [2], ae_o [2], ovf_o [2], unf_o [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus the sticky flags and the registered read word.
    logic [DW-1:0] mq [$];
    bit            m_ovf = 1'b0, m_unf = 1'b0;
    logic [DW-1:0] m_rd = '0;

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) u_reg (
        .wclk(wclk), .wrst(wrst), .wpush(wpush), .wdata(wdata), .wfull(wfull_o[0]),
        .rpop(rpop), .rdata(rdata_o[0]), .rempty(rempty_o[0]), .level(level_o[0]),
        .almost_full(af_o[0]), .almost_empty(ae_o[0]), .overflow(ovf_o[0]),
        .underflow(unf_o[0]), .err_clr(err_clr)
    );

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .wclk(wclk), .wrst(wrst), .wpush(wpush), .wdata(wdata), .wfull(wfull_o[1]),
        .rpop(rpop), .rdata(rdata_o[1]), .rempty(rempty_o[1]), .level(level_o[1]),
        .almost_full(af_o[1]), .almost_empty(ae_o[1]), .overflow(ovf_o[1]),
        .underflow(unf_o[1]), .err_clr(err_clr)
    );

    always #5 wclk = ~wclk;

    // Expected {wfull, rempty, almost_full, almost_empty, overflow, underflow, level}.
    function automatic logic [9:0] model_flags();
        int sz;
        sz = mq.size();
        return {sz == DEPTH, sz == 0, sz >= DEPTH - 2, sz <= 2, m_ovf, m_unf, LW'(sz)};
    endfunction

    // Drive one cycle of inputs, advance the model and return 1 ns after the clock edge.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
        bit pop_ok, push_ok;
        wpush = p; wdata = d; rpop = r; err_clr = c; wrst = rs;
        if (rs) begin
            mq.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0;
        end else begin
            pop_ok  = r && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || pop_ok);
            if (pop_ok) m_rd = mq.pop_front();
            if (push_ok) mq.push_back(d);
            m_ovf = (m_ovf && !c) || (p && !push_ok);
            m_unf = (m_unf && !c) || (r && !pop_ok);
        end
        @(posedge wclk);
        #1;
        wpush = 1'b0; rpop = 1'b0; err_clr = 1'b0; wrst = 1'b0;
    endtask

    task automatic fill_seq();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [9:0] got;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            got = {wfull_o[k], rempty_o[k], af_o[k], ae_o[k], ovf_o[k], unf_o[k], level_o[k]};
            n_vec++;
            if (got !== 10'b0_1_0_1_0_0_0000) begin
                n_err++;
                $display("FAIL reset_flags[%0d]: got %b expected %b", k, got, 10'b0101000000);
            end
        end
        n_vec++;
        if (rdata_o[0] !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_rdata: got %h expected 0000", rdata_o[0]);
        end
    endtask

    task automatic test_fill_drain();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (level_o[0] !== LW'(i) || af_o[0] !== (i >= 6)) begin
                n_err++;
                $display("FAIL fill_level: got level=%0d af=%b expected level=%0d af=%b",
                         level_o[0], af_o[0], i, (i >= 6));
            end
        end
        n_vec++;
        if (wfull_o[0] !== 1'b1 || wfull_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: got %b/%b expected 1/1", wfull_o[0], wfull_o[1]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            n_vec++;
            if (rdata_o[1] !== DW'(i)) begin
                n_err++;
                $display("FAIL drain_fwft_head: got %h expected %h", rdata_o[1], DW'(i));
            end
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (rdata_o[0] !== DW'(i)) begin
                n_err++;
                $display("FAIL drain_rdata: got %h expected %h", rdata_o[0], DW'(i));
            end
        end
        n_vec++;
        if (rempty_o[0] !== 1'b1 || rempty_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL drain_empty: got %b/%b expected 1/1", rempty_o[0], rempty_o[1]);
        end
    endtask

    task automatic test_overflow();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        fill_seq();
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (ovf_o[0] !== 1'b1 || ovf_o[1] !== 1'b1 || level_o[0] !== LW'(8)) begin
            n_err++;
            $display("FAIL overflow_set: got ovf=%b/%b level=%0d expected ovf=1/1 level=8",
                     ovf_o[0], ovf_o[1], level_o[0]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (rdata_o[0] !== DW'(i)) begin
                n_err++;
                $display("FAIL overflow_drain: got %h expected %h", rdata_o[0], DW'(i));
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (ovf_o[0] !== 1'b0 || ovf_o[1] !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clr: got %b/%b expected 0/0", ovf_o[0], ovf_o[1]);
        end
    endtask

    task automatic test_full_push_pop();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        fill_seq();
        step(1'b1, 16'h0009, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (level_o[0] !== LW'(8) || wfull_o[0] !== 1'b1 || rdata_o[0] !== 16'h0001 || ovf_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL full_push_pop: got level=%0d full=%b rdata=%h ovf=%b expected 8 1 0001 0",
                     level_o[0], wfull_o[0], rdata_o[0], ovf_o[0]);
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (rdata_o[0] !== DW'(i + 1)) begin
                n_err++;
                $display("FAIL wrap_drain: got %h expected %h", rdata_o[0], DW'(i + 1));
            end
        end
    endtask

    task automatic test_underflow();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (unf_o[0] !== 1'b1 || level_o[0] !== LW'(0) || rdata_o[0] !== 16'h0000) begin
            n_err++;
            $display("FAIL underflow_set: got unf=%b level=%0d rdata=%h expected 1 0 0000",
                     unf_o[0], level_o[0], rdata_o[0]);
        end
        step(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (level_o[1] !== LW'(1) || unf_o[1] !== 1'b1 || rempty_o[1] !== 1'b0 || rdata_o[1] !== 16'h00AA) begin
            n_err++;
            $display("FAIL empty_push_pop: got level=%0d unf=%b empty=%b rdata=%h expected 1 1 0 00aa",
                     level_o[1], unf_o[1], rempty_o[1], rdata_o[1]);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (rdata_o[0] !== 16'h00AA || rempty_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL retained_word: got rdata=%h empty=%b expected 00aa 1", rdata_o[0], rempty_o[0]);
        end
    endtask

    task automatic test_fwft_and_reset();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (rempty_o[1] !== 1'b0 || rdata_o[1] !== 16'h1234) begin
            n_err++;
            $display("FAIL fwft_show: got empty=%b rdata=%h expected 0 1234", rempty_o[1], rdata_o[1]);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (rempty_o[1] !== 1'b1) begin
            n_err++;
            $display("FAIL fwft_pop: got empty=%b expected 1", rempty_o[1]);
        end
        for (int i = 0; i < 5; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (level_o[1] !== LW'(5)) begin
            n_err++;
            $display("FAIL pre_reset_level: got %0d expected 5", level_o[1]);
        end
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (level_o[0] !== LW'(0) || level_o[1] !== LW'(0) || rempty_o[1] !== 1'b1 || rempty_o[0] !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: got level=%0d/%0d empty=%b/%b expected 0/0 1/1",
                     level_o[0], level_o[1], rempty_o[0], rempty_o[1]);
        end
    endtask

    task automatic test_random();
        int bias;
        logic [9:0] got, exp;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 600; n++) begin
            bias = ((n / 40) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < bias, DW'($urandom), $urandom_range(99) < (100 - bias),
                 $urandom_range(15) == 0, $urandom_range(199) == 0);
            exp = model_flags();
            for (int k = 0; k < 2; k++) begin
                got = {wfull_o[k], rempty_o[k], af_o[k], ae_o[k], ovf_o[k], unf_o[k], level_o[k]};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL rand_flags[%0d] cycle %0d: got %b expected %b", k, n, got, exp);
                end
            end
            n_vec++;
            if (rdata_o[0] !== m_rd) begin
                n_err++;
                $display("FAIL rand_rdata_reg cycle %0d: got %h expected %h", n, rdata_o[0], m_rd);
            end
            if (mq.size() > 0) begin
                n_vec++;
                if (rdata_o[1] !== mq[0]) begin
                    n_err++;
                    $display("FAIL rand_rdata_fwft cycle %0d: got %h expected %h", n, rdata_o[1], mq[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_fwft_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock producer-consumer FIFO. Successor to the fixed 16-bit push/pop buffer: data width and depth are generic, read mode is selectable (registered or first-word-fall-through), and it adds an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. Sits between a producer master (wpush/wdata/wfull) and a consumer master (rpop/rdata/rempty) inside one clock domain.

Parameters:
DATA_W, 16, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
FWFT, 0, 0 = registered read (rdata valid 1 cycle after pop); 1 = first-word-fall-through (head shown while !rempty)
AFULL_TH, DEPTH-2, almost_full asserts when level >= AFULL_TH (1..DEPTH)
AEMPTY_TH, 2, almost_empty asserts when level <= AEMPTY_TH (0..DEPTH-1)

Ports:
wclk  input  1  clock, all logic rising-edge
wrst  input  1  synchronous reset, active-high
wpush  input  1  write request
wdata  input  DATA_W  write data, sampled on accepted push
wfull  output  1  level == DEPTH
rpop  input  1  read request
rdata  output  DATA_W  read data
rempty  output  1  level == 0
level  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH
almost_full  output  1  level >= AFULL_TH
almost_empty  output  1  level <= AEMPTY_TH
overflow  output  1  sticky: push rejected while full
underflow  output  1  sticky: pop rejected while empty
err_clr  input  1  clears overflow/underflow

Behaviour:
- Reset (wrst=1 at wclk edge): pointers/level to 0, contents discarded; outputs: wfull=0, rempty=1, level=0, almost_full=0 (AFULL_TH>=1), almost_empty=1, overflow=0, underflow=0, rdata=0. Reset mid-operation discards all entries; wpush/rpop ignored that cycle.
- Storage: DEPTH x DATA_W array; write/read pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)), wrap modulo DEPTH; level is a register.
- Push accept: wpush && (!wfull || rpop_acc). Pop accept (rpop_acc): rpop && !rempty.
- Full + push + pop same cycle: both accepted, level unchanged, wfull stays 1.
- Empty + push + pop same cycle: push accepted, pop rejected, underflow set; level becomes 1.
- Push while full without pop: data dropped, contents/level unchanged, overflow=1 next cycle.
- Pop while empty: no state change except underflow=1 next cycle; rdata holds.
- Level update: +1 push only, -1 pop only, 0 both/neither; registered, visible the cycle after the edge.
- wfull, rempty, almost_full, almost_empty: combinational decodes of level register (no extra latency vs level).
- FWFT=0: on accepted pop at edge t, rdata <= mem[rptr]; valid from edge t onward, held until next accepted pop.
- FWFT=1: rdata = mem[rptr] whenever rempty=0 (combinational read of head); rpop consumes head, next entry shown after edge. Word pushed into empty FIFO at edge t visible on rdata after t. rdata value while rempty=1 is don't-care.
- Sticky errors: set on rejected event, cleared by err_clr; if set-event and err_clr coincide, set wins.
- Write data never read in same cycle it is written (no bypass beyond FWFT behaviour above).

Test Plan:
- Reset then idle, DEPTH=8: -> rempty=1, wfull=0, level=0, almost_empty=1, overflow=underflow=0, rdata=0.
- FWFT=0: push 0x0001..0x0008 on 8 cycles -> level=8, wfull=1, almost_full=1 from level 6; pop 8 cycles -> rdata 0x0001..0x0008 each 1 cycle after pop, rempty=1 at end.
- Full, 9th push 0xDEAD -> overflow=1, level=8; pop all -> 0xDEAD never seen; err_clr -> overflow=0.
- Full, simultaneous push 0x0009 + pop -> level stays 8, popped 0x0001; after draining, last word 0x0009 (pointer wrap).
- Empty, pop -> underflow=1, level 0; empty + push 0x00AA + pop -> level=1, underflow=1, 0x00AA retained.
- FWFT=1: push 0x1234 into empty -> next cycle rempty=0, rdata=0x1234 without pop; pop -> rempty=1. Assert wrst with level=5 -> level=0, rempty=1 next cycle.
